game_supervisor: RTL

Parametrised game-flow controller for the Pong top level. It replaces the ad-hoc tick divider, enter-button debounce and menu FSM with one synchronous block. It emits single-cycle tick enables instead of derived clocks, supports 2–4 players, keeps per-player scores and detects a winner. It adds a serve countdown after each point. Its outputs drive the ball/paddle/menu objects and the RGB compositing network.

---
 rtl/game_supervisor.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/game_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : game_supervisor
// Description : Pong game-flow controller. Conditions the enter button,
//               divides clk into single-cycle tick strobes, sequences the
//               START/SERVE/PLAY/PAUSE/OVER screens, keeps per-player scores
//               and flags the winner.
// Revision    : 1.0 - initial release
// ============================================================================
module game_supervisor #(
  parameter int TICK_DIV        = 6000,
  parameter int DEBOUNCE_CYCLES = 60000,
  parameter int NUM_PLAYERS     = 2,
  parameter int SCORE_W         = 4,
  parameter int WIN_SCORE       = 9,
  parameter int SERVE_TICKS     = 60
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           button_enter,
  input  logic [NUM_PLAYERS-1:0]         point,
  input  logic                           pause_sel,
  output logic                           tick_game,
  output logic                           tick_menu,
  output logic                           enable_start,
  output logic                           enable_pause,
  output logic                           enable_game,
  output logic                           enable_over,
  output logic                           serve,
  output logic                           round_reset,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score,
  output logic [NUM_PLAYERS-1:0]         winner
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SRV_W = $clog2(SERVE_TICKS + 1);
  localparam int IDX_W = $clog2(NUM_PLAYERS);

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [SRV_W-1:0]   SRV_LOAD = SRV_W'(SERVE_TICKS);
  localparam logic [SRV_W-1:0]   SRV_ONE  = SRV_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);
  localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // Button conditioning
  logic [1:0]       sync_q;
  logic [DEB_W-1:0] deb_cnt;
  logic             deb_level;
  logic             deb_prev;
  logic             enter_pulse;

  // Tick divider
  logic [DIV_W-1:0] div_cnt;
  logic             strobe;

  // Game flow
  state_t           state;
  state_t           next_state;
  logic [SRV_W-1:0] serve_cnt;
  logic [SCORE_W-1:0] score_q [NUM_PLAYERS];

  logic               any_point;
  logic [IDX_W-1:0]   hit_idx;
  logic [SCORE_W-1:0] hit_score;
  logic               hit_wins;

  logic start_round;
  logic dec_serve;
  logic clear_scores;
  logic score_inc;
  logic set_winner;

  // Two-flop synchroniser for the asynchronous button
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], button_enter};
    end
  end

  // Debounce: the accepted level flips only after DEBOUNCE_CYCLES+1 consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_cnt   <= '0;
      deb_level <= 1'b0;
      deb_prev  <= 1'b0;
    end else begin
      deb_prev <= deb_level;
      if (sync_q[1] == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_level <= sync_q[1];
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign enter_pulse = deb_level & ~deb_prev;

  // Free-running divider; never disturbed by screen changes
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign strobe = (div_cnt == DIV_LAST);

  // Lowest-index scorer wins a simultaneous point; higher bits are dropped
  always_comb begin
    hit_idx   = '0;
    hit_score = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (point[i]) begin
        hit_idx   = IDX_W'(i);
        hit_score = score_q[i];
      end
    end
  end

  assign any_point = |point;
  assign hit_wins  = ((hit_score + SCORE_ONE) == WIN_VAL);

  // Screen sequencing: next state and one-cycle control requests
  always_comb begin
    next_state   = state;
    start_round  = 1'b0;
    dec_serve    = 1'b0;
    clear_scores = 1'b0;
    score_inc    = 1'b0;
    set_winner   = 1'b0;
    case (state)
      ST_START: begin
        if (enter_pulse) begin
          next_state   = ST_SERVE;
          clear_scores = 1'b1;
          start_round  = 1'b1;
        end
      end
      ST_SERVE: begin
        if (strobe) begin
          dec_serve = 1'b1;
          if (serve_cnt <= SRV_ONE) begin
            next_state = ST_PLAY;
          end
        end
      end
      ST_PLAY: begin
        if (any_point) begin
          score_inc = 1'b1;
          if (hit_wins) begin
            next_state = ST_OVER;
            set_winner = 1'b1;
          end else begin
            next_state  = ST_SERVE;
            start_round = 1'b1;
          end
        end else if (enter_pulse) begin
          next_state = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (enter_pulse) begin
          next_state = pause_sel ? ST_START : ST_PLAY;
        end
      end
      ST_OVER: begin
        if (enter_pulse) begin
          next_state = ST_START;
        end
      end
      default: begin
        next_state = ST_START;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_START;
    end else begin
      state <= next_state;
    end
  end

  // Serve countdown, loaded whenever a new round begins
  always_ff @(posedge clk) begin
    if (reset) begin
      serve_cnt <= '0;
    end else if (start_round) begin
      serve_cnt <= SRV_LOAD;
    end else if (dec_serve && serve_cnt != '0) begin
      serve_cnt <= serve_cnt - 1'b1;
    end
  end

  // Registered recentre pulse for the cycle after a round starts
  always_ff @(posedge clk) begin
    if (reset) begin
      round_reset <= 1'b0;
    end else begin
      round_reset <= start_round;
    end
  end

  // Per-player scores; saturate at WIN_SCORE so they can never wrap
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (reset || clear_scores) begin
        score_q[i] <= '0;
      end else if (score_inc && hit_idx == IDX_W'(i) && score_q[i] != WIN_VAL) begin
        score_q[i] <= score_q[i] + SCORE_ONE;
      end
    end
  end

  // Winner is only ever visible while the OVER screen is shown
  always_ff @(posedge clk) begin
    if (reset) begin
      winner <= '0;
    end else if (set_winner) begin
      winner <= NUM_PLAYERS'(1) << hit_idx;
    end else if (next_state != ST_OVER) begin
      winner <= '0;
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_score_pack
    assign score[g*SCORE_W +: SCORE_W] = score_q[g];
  end

  assign tick_game    = strobe & (state == ST_PLAY);
  assign tick_menu    = strobe & (state != ST_PLAY);
  assign enable_start = (state == ST_START);
  assign enable_pause = (state == ST_PAUSE);
  assign enable_game  = (state == ST_SERVE) | (state == ST_PLAY);
  assign enable_over  = (state == ST_OVER);
  assign serve        = (state == ST_SERVE);

endmodule
`default_nettype wire
